alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: NREQ, default 2, number of requesters sharing the ALU, legal range 2..4.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  NREQ  per-requester operation request.
REQ-005 req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-006 req_a  input  4*NREQ  operand A, requester i at bits [4i+3:4i].
REQ-007 req_b  input  4*NREQ  operand B, same packing as req_a.
REQ-008 req_op  input  3*NREQ  opcode, requester i at bits [3i+2:3i].
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  response consumer accept.
REQ-011 rsp_id  output  2  index of requester that issued the response.
REQ-012 rsp_result  output  4  ALU result.
REQ-013 rsp_err  output  1  opcode was illegal (101, 110, 111).

Function
REQ-014 FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-015 IDLE: if any req_valid, assert req_ready only for round-robin winner; transfer when req_valid&req_ready; latch A, B, op, id; go EXEC.
REQ-016 IDLE with no req_valid: all req_ready low, stay IDLE.
REQ-017 Round-robin: search starts at (last_grant+1) mod NREQ, first valid wins; last_grant updates on every transfer.
REQ-018 EXEC: one cycle; compute on latched operands, register result; go RESP.
REQ-019 Opcodes: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 ~A; results truncated to 4 bits (mod 16 wrap).
REQ-020 Illegal opcode: rsp_result 0000, rsp_err 1; legal opcode: rsp_err 0.
REQ-021 RESP: rsp_valid high, rsp_id/rsp_result/rsp_err stable until rsp_valid&rsp_ready; then IDLE.
REQ-022 Latency: transfer at cycle N -> rsp_valid high at cycle N+2 earliest; throughput one op per 3 cycles with rsp_ready held high.
REQ-023 req_ready all low in EXEC and RESP; requests wait without loss (requester holds valid).
REQ-024 Request changes after transfer do not affect the in-flight result.
REQ-025 rsp_ready ignored outside RESP.

Reset
REQ-026 On rst high, immediately: state IDLE, req_ready 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_err 0, last_grant NREQ-1 (requester 0 wins first).
REQ-027 Reset mid-EXEC or mid-RESP discards the operation; no response issued after release.

Configuration
REQ-028 Macro ALU_ARBITER_FLAGS_EN defined: extra outputs rsp_zero (result==0) and rsp_carry (carry-out of ADD, borrow of SUB, 0 otherwise), registered with rsp_result, reset 0.
REQ-029 Macro undefined: ports rsp_zero and rsp_carry absent; all other behaviour identical.

Structure
REQ-030 Shared package alu_pkg holds opcode constants (OP_ADD..OP_NOT), the 3-state FSM enum, data width 4, opcode width 3.
REQ-031 Combinational compute in sub-module alu_core (A, B, op -> result, err, carry); alu_arbiter owns FSM, arbitration, registers.

Verification
REQ-032 Single op: req_valid=01, A=0111, B=0101, op=000 -> rsp_result 1100, rsp_id 0, rsp_err 0, rsp_valid 2 cycles after transfer.
REQ-033 Wrap/borrow: A=0011, B=0101, op=001 -> rsp_result 1110; with FLAGS_EN rsp_carry 1, rsp_zero 0.
REQ-034 Fairness: both valid continuously, rsp_ready=1 -> grants 0,1,0,1; no requester served twice in a row.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready low; one transfer per rsp handshake.
REQ-036 Illegal op 110 from requester 1 -> rsp_result 0000, rsp_err 1, rsp_id 1.
REQ-037 Reset asserted in EXEC -> all outputs 0 immediately; no rsp_valid after release until a new transfer.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: data/opcode widths, opcode values and FSM states.
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_NOT = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational 4-bit ALU: result, illegal-opcode flag and carry/borrow out.
module alu_core
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result,
    output logic              err,
    output logic              carry
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    // The extra MSB of the subtraction is set exactly when a < b, i.e. a borrow.
    assign diff = {1'b0, a} - {1'b0, b};
    assign err  = ~op_is_legal(op);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_SUB: begin
                result = diff[DATA_W-1:0];
                carry  = diff[DATA_W];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_NOT:  result = ~a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters (IDLE -> EXEC -> RESP).
// Optional zero/carry response flags are enabled by defining ALU_ARBITER_FLAGS_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [4*NREQ-1:0]      req_a,
    input  logic [4*NREQ-1:0]      req_b,
    input  logic [3*NREQ-1:0]      req_op,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_id,
    output logic [DATA_W-1:0]      rsp_result,
    output logic                   rsp_err
`ifdef ALU_ARBITER_FLAGS_EN
    ,
    output logic                   rsp_zero,
    output logic                   rsp_carry
`endif
);

    state_t            state_reg, state_next;
    logic [1:0]        last_grant_reg;
    logic [DATA_W-1:0] a_reg, b_reg;
    logic [OP_W-1:0]   op_reg;
    logic [1:0]        id_reg;
    logic [DATA_W-1:0] result_reg;
    logic              err_reg;
    logic [1:0]        rsp_id_reg;

    logic [DATA_W-1:0] a_arr  [NREQ];
    logic [DATA_W-1:0] b_arr  [NREQ];
    logic [OP_W-1:0]   op_arr [NREQ];

    logic              win_found;
    logic [1:0]        win_idx;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic [OP_W-1:0]   sel_op;
    logic              grant_en;
    logic              transfer;

    logic [DATA_W-1:0] core_result;
    logic              core_err;
    logic              core_carry;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
        assign a_arr[gi]     = req_a[4*gi +: 4];
        assign b_arr[gi]     = req_b[4*gi +: 4];
        assign op_arr[gi]    = req_op[3*gi +: 3];
        assign req_ready[gi] = grant_en && (win_idx == 2'(gi));
    end

    // Search starts just after the last winner so every valid requester is reached within NREQ grants.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_grant_reg;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!win_found && req_valid[i] && (((int'(last_grant_reg) + k) % NREQ) == i)) begin
                    win_found = 1'b1;
                    win_idx   = 2'(i);
                end
            end
        end
        sel_a  = a_arr[0];
        sel_b  = b_arr[0];
        sel_op = op_arr[0];
        for (int i = 1; i < NREQ; i++) begin
            if (win_idx == 2'(i)) begin
                sel_a  = a_arr[i];
                sel_b  = b_arr[i];
                sel_op = op_arr[i];
            end
        end
    end

    // Held low while rst is asserted so no grant is visible during reset.
    assign grant_en = (state_reg == ST_IDLE) && win_found && !rst;
    assign transfer = |(req_valid & req_ready);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (transfer) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    alu_core u_core (
        .a      (a_reg),
        .b      (b_reg),
        .op     (op_reg),
        .result (core_result),
        .err    (core_err),
        .carry  (core_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 2'(NREQ - 1);
            a_reg          <= '0;
            b_reg          <= '0;
            op_reg         <= '0;
            id_reg         <= '0;
            result_reg     <= '0;
            err_reg        <= 1'b0;
            rsp_id_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && transfer) begin
                a_reg          <= sel_a;
                b_reg          <= sel_b;
                op_reg         <= sel_op;
                id_reg         <= win_idx;
                last_grant_reg <= win_idx;
            end
            if (state_reg == ST_EXEC) begin
                result_reg <= core_result;
                err_reg    <= core_err;
                rsp_id_reg <= id_reg;
            end
        end
    end

`ifdef ALU_ARBITER_FLAGS_EN
    logic zero_reg;
    logic carry_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_reg  <= 1'b0;
            carry_reg <= 1'b0;
        end else if (state_reg == ST_EXEC) begin
            zero_reg  <= (core_result == '0);
            carry_reg <= core_carry;
        end
    end

    assign rsp_zero  = zero_reg;
    assign rsp_carry = carry_reg;
`else
    logic unused_carry;
    assign unused_carry = core_carry;
`endif

    assign rsp_valid  = (state_reg == ST_RESP);
    assign rsp_id     = rsp_id_reg;
    assign rsp_result = result_reg;
    assign rsp_err    = err_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter against a transaction-level reference model.
// Covers the ALU_ARBITER_FLAGS_EN outputs when that macro is defined.
module tb_alu_arbiter;

    localparam int NREQ = 2;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [4*NREQ-1:0]   req_a;
    logic [4*NREQ-1:0]   req_b;
    logic [3*NREQ-1:0]   req_op;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [1:0]          rsp_id;
    logic [3:0]          rsp_result;
    logic                rsp_err;
`ifdef ALU_ARBITER_FLAGS_EN
    logic                rsp_zero;
    logic                rsp_carry;
`endif

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err)
`ifdef ALU_ARBITER_FLAGS_EN
        ,
        .rsp_zero   (rsp_zero),
        .rsp_carry  (rsp_carry)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requesters hold their operation until it is accepted.
    bit         hold_v  [NREQ];
    logic [3:0] hold_a  [NREQ];
    logic [3:0] hold_b  [NREQ];
    logic [2:0] hold_op [NREQ];
    int         gen_pct = 0;
    int         rr_pct  = 100;

    // Reference model: one outstanding operation, response visible 2 cycles after acceptance.
    bit         busy = 0;
    int         age  = 0;
    int         last = NREQ - 1;
    int         e_id;
    logic [3:0] e_res;
    bit         e_err, e_carry;

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int lst);
        for (int k = 1; k <= NREQ; k++)
            if (v[(lst + k) % NREQ]) return (lst + k) % NREQ;
        return -1;
    endfunction

    task automatic alu_ref(input int a, input int b, input int op,
                           output logic [3:0] res, output bit err, output bit carry);
        int r;
        err = 0; carry = 0; r = 0;
        case (op)
            0: begin r = (a + b) % 16; carry = (a + b) > 15; end
            1: begin r = (a - b + 16) % 16; carry = (a < b); end
            2: r = a & b;
            3: r = a | b;
            4: r = 15 - a;
            default: begin r = 0; err = 1; end
        endcase
        res = 4'(r);
    endtask

    task automatic set_hold(input int i, input int a, input int b, input int op);
        hold_v[i] = 1; hold_a[i] = 4'(a); hold_b[i] = 4'(b); hold_op[i] = 3'(op);
    endtask

    task automatic cycle();
        logic [NREQ-1:0] exp_ready;
        bit exp_rv;
        int w;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (!hold_v[i] && $urandom_range(99) < gen_pct)
                set_hold(i, $urandom_range(15), $urandom_range(15), $urandom_range(7));
            req_valid[i] = hold_v[i];
            req_a[4*i +: 4]  = hold_v[i] ? hold_a[i]  : 4'($urandom_range(15));
            req_b[4*i +: 4]  = hold_v[i] ? hold_b[i]  : 4'($urandom_range(15));
            req_op[3*i +: 3] = hold_v[i] ? hold_op[i] : 3'($urandom_range(7));
        end
        rsp_ready = ($urandom_range(99) < rr_pct);
        #1;
        w = rr_pick(req_valid, last);
        exp_ready = '0;
        if (!busy && w >= 0) exp_ready[w] = 1'b1;
        exp_rv = busy && (age >= 2);
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv) begin
            check("rsp_id", 32'(rsp_id), 32'(e_id));
            check("rsp_result", 32'(rsp_result), 32'(e_res));
            check("rsp_err", 32'(rsp_err), 32'(e_err));
`ifdef ALU_ARBITER_FLAGS_EN
            check("rsp_zero", 32'(rsp_zero), 32'(e_res == 4'd0));
            check("rsp_carry", 32'(rsp_carry), 32'(e_carry));
`endif
        end
        if (busy) begin
            if (exp_rv && rsp_ready) begin
                busy = 0;
                $display("rsp id=%0d result=%0h err=%0b", e_id, e_res, e_err);
            end else begin
                age++;
            end
        end else if (w >= 0) begin
            alu_ref(hold_a[w], hold_b[w], hold_op[w], e_res, e_err, e_carry);
            e_id = w;
            last = w;
            hold_v[w] = 0;
            busy = 1;
            age = 1;
        end
    endtask

    task automatic drain(input int max_cycles);
        bit done;
        done = 0;
        for (int n = 0; n < max_cycles && !done; n++) begin
            done = !busy;
            for (int i = 0; i < NREQ; i++) if (hold_v[i]) done = 0;
            if (!done) cycle();
        end
        check("drain_timeout", 32'(done), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_id"}, 32'(rsp_id), 32'd0);
        check({tag, "_result"}, 32'(rsp_result), 32'd0);
        check({tag, "_err"}, 32'(rsp_err), 32'd0);
`ifdef ALU_ARBITER_FLAGS_EN
        check({tag, "_zero"}, 32'(rsp_zero), 32'd0);
        check({tag, "_carry"}, 32'(rsp_carry), 32'd0);
`endif
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) hold_v[i] = 0;
        rst = 1'b1;
        req_valid = '1;
        req_a = '0; req_b = '0; req_op = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        req_valid = '0;
        rst = 1'b0;

        // Single ADD from requester 0: 7 + 5 = 12.
        gen_pct = 0; rr_pct = 100;
        set_hold(0, 7, 5, 0);
        drain(10);

        // SUB with wrap/borrow: 3 - 5 = 14.
        set_hold(0, 3, 5, 1);
        drain(10);

        // Fairness with both requesters continuously valid.
        gen_pct = 100;
        repeat (14) cycle();
        gen_pct = 0;
        drain(20);

        // Backpressure: response held for 5 cycles while requester 1 waits.
        set_hold(0, 9, 4, 3);
        set_hold(1, 6, 2, 2);
        rr_pct = 0;
        repeat (7) cycle();
        rr_pct = 100;
        drain(20);

        // Illegal opcode from requester 1.
        set_hold(1, 9, 3, 6);
        drain(10);

        // Randomized traffic with random response backpressure.
        gen_pct = 40; rr_pct = 70;
        repeat (300) cycle();
        gen_pct = 0; rr_pct = 100;
        drain(40);

        // Reset in EXEC: leave a nonzero result registered, then abort the next op.
        set_hold(0, 7, 5, 0);
        drain(10);
        set_hold(0, 1, 1, 0);
        cycle();
        check("exec_setup", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = '1;
        #1;
        check_all_zero("rst_exec");
        @(posedge clk);
        #1;
        req_valid = '0;
        rst = 1'b0;
        busy = 0;
        last = NREQ - 1;
        repeat (3) cycle();
        set_hold(0, 2, 2, 4);
        set_hold(1, 8, 8, 0);
        drain(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0t expected=done", $time);
        $fatal(1, "timeout");
    end

endmodule
